// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier that drives an
// external prefix_tree_adder (a/b/cin out, sum/cout back) and produces one partial
// product per clock. Optional feature macro: ZERO_BYPASS_EN (zero operands skip BUSY).
module shift_add_multiplier #(
  parameter int width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width-1:0]   mcand,
  input  logic [width-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width-1:0] product,
  output logic [width-1:0]   add_a,
  output logic [width-1:0]   add_b,
  output logic               add_cin,
  input  logic [width-1:0]   add_sum,
  input  logic               add_cout
);

  // count must be at least one bit wide even when width is 1
  localparam int cw = (width > 1) ? $clog2(width) : 1;
  localparam logic [cw-1:0] last_count = cw'(width - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [width-1:0] mc_r;
  logic [width-1:0] hi_r;
  logic [width-1:0] lo_r;
  logic [cw-1:0]    count;
  logic             zero_op;

  // The adder result and the low half shift right together by one bit each step;
  // building them as width+1 concatenations keeps the slices legal for width=1.
  logic [width:0] sum_cat;
  logic [width:0] lo_cat;

  assign sum_cat = {add_cout, add_sum};
  assign lo_cat  = {add_sum[0], lo_r};

  // Flag operand pairs whose product is trivially zero (only when the bypass is built in)
  always_comb begin
    zero_op = 1'b0;
`ifdef ZERO_BYPASS_EN
    zero_op = (mcand == '0) || (mplier == '0);
`else
    zero_op = 1'b0;
`endif
  end

  // Feed the adder from the registers while BUSY; keep its inputs quiet otherwise
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == BUSY) begin
      add_a = hi_r;
      add_b = lo_r[0] ? mc_r : '0;
    end
  end

  assign product = out_valid ? {hi_r, lo_r} : '0;

  // Control FSM with registered handshake outputs and the shift/add datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mc_r      <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mc_r     <= mcand;
            hi_r     <= '0;
            lo_r     <= mplier;
            count    <= '0;
            in_ready <= 1'b0;
            if (zero_op) begin
              lo_r      <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          hi_r  <= sum_cat[width:1];
          lo_r  <= lo_cat[width:1];
          count <= count + cw'(1);
          if (count == last_count) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: bench for shift_add_multiplier (width=4) with a behavioural
// stand-in for the attached prefix_tree_adder. Honours ZERO_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_shift_add_multiplier;

  localparam int width = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [width-1:0]   mcand;
  logic [width-1:0]   mplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*width-1:0] product;
  logic [width-1:0]   add_a;
  logic [width-1:0]   add_b;
  logic               add_cin;
  logic [width-1:0]   add_sum;
  logic               add_cout;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [width-1:0]   a;
    logic [width-1:0]   b;
    logic [2*width-1:0] exp;
    int                 stall;
  } vec_t;

  vec_t vecs[6];

  shift_add_multiplier #(.width(width)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mcand(mcand),
    .mplier(mplier),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .add_a(add_a),
    .add_b(add_b),
    .add_cin(add_cin),
    .add_sum(add_sum),
    .add_cout(add_cout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Plain combinational adder standing in for prefix_tree_adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{width{1'b0}}, add_cin};

  function automatic logic [2*width-1:0] model_product(input logic [width-1:0] a, input logic [width-1:0] b);
    logic [2*width-1:0] wa;
    logic [2*width-1:0] wb;
    wa = {{width{1'b0}}, a};
    wb = {{width{1'b0}}, b};
    return wa * wb;
  endfunction

  function automatic int model_latency(input logic [width-1:0] a, input logic [width-1:0] b);
`ifdef ZERO_BYPASS_EN
    if (a == '0 || b == '0) return 1;
`endif
    return width + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One full transaction: accept, wait for the product, optionally stall, then hand it off
  task automatic applyStimulus(input logic [width-1:0] a, input logic [width-1:0] b,
                               input logic [2*width-1:0] exp, input int stall, input string tag);
    int  k;
    int  lat;
    bit  seen;
    bit  ready_low_ok;
    bit  cin_ok;
    bit  hold_ok;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_ready_timeout"}, in_ready, 1);
      return;
    end
    mcand     = a;
    mplier    = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    lat = 0;
    ready_low_ok = 1;
    cin_ok = 1;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(negedge clk);
      if (add_cin !== 1'b0) cin_ok = 0;
      if (out_valid) begin
        seen = 1;
        lat  = i;
      end else if (in_ready !== 1'b0) begin
        ready_low_ok = 0;
      end
    end
    if (!seen) begin
      checkOutput({tag, "_valid_timeout"}, out_valid, 1);
      return;
    end
    checkOutput({tag, "_latency"}, lat, model_latency(a, b));
    checkOutput({tag, "_product"}, product, exp);
    checkOutput({tag, "_ready_low"}, {63'd0, ready_low_ok}, 1);
    checkOutput({tag, "_cin_zero"}, {63'd0, cin_ok}, 1);
    checkOutput({tag, "_done_adder_idle"}, {add_a, add_b}, 0);
    hold_ok = 1;
    for (int j = 0; j < stall; j++) begin
      @(negedge clk);
      if (product !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) hold_ok = 0;
    end
    if (stall > 0) checkOutput({tag, "_hold_stable"}, {63'd0, hold_ok}, 1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int              n_acc;
    int              acc_cycle[$];
    logic [2*width-1:0] prods[$];
    logic [width-1:0] bb_a[3];
    logic [width-1:0] bb_b[3];
    logic [width-1:0] ra;
    logic [width-1:0] rb;

    vecs[0] = '{a: 4'd13, b: 4'd11, exp: 8'h8F, stall: 0};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'hE1, stall: 0};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  exp: 8'h00, stall: 0};
    vecs[3] = '{a: 4'd7,  b: 4'd6,  exp: 8'h2A, stall: 10};
    vecs[4] = '{a: 4'd3,  b: 4'd5,  exp: 8'h0F, stall: 0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  exp: 8'h00, stall: 2};

    // Reset with a competing in_valid: reset must win
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    mcand     = 4'd5;
    mplier    = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_product", product, 0);
    checkOutput("reset_adder", {add_a, add_b, add_cin}, 0);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Directed table
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].stall, $sformatf("vec%0d", v));
    end

    // Reset in the middle of BUSY discards the operation
    @(negedge clk);
    mcand     = 4'd9;
    mplier    = 4'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstbusy_first_ready", in_ready, 0);
    checkOutput("rstbusy_first_adder", {add_a, add_b}, {4'd0, 4'd9});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstbusy_ready", in_ready, 1);
    checkOutput("rstbusy_out_valid", out_valid, 0);
    checkOutput("rstbusy_product", product, 0);
    checkOutput("rstbusy_adder", {add_a, add_b}, 0);
    applyStimulus(4'd3, 4'd5, 8'h0F, 0, "after_rst");

    // Back-to-back with in_valid held high
    bb_a[0] = 4'd1;  bb_b[0] = 4'd1;
    bb_a[1] = 4'd2;  bb_b[1] = 4'd8;
    bb_a[2] = 4'd15; bb_b[2] = 4'd1;
    n_acc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    mcand     = bb_a[0];
    mplier    = bb_b[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 60 && prods.size() < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid) prods.push_back(product);
      if (!in_ready) begin
        if (n_acc < 3) begin
          mcand  = bb_a[n_acc];
          mplier = bb_b[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end else if (in_valid) begin
        acc_cycle.push_back(c);
        n_acc++;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_count", prods.size(), 3);
    for (int i = 0; i < prods.size() && i < 3; i++) begin
      checkOutput($sformatf("b2b_product%0d", i), prods[i], model_product(bb_a[i], bb_b[i]));
    end
    for (int i = 1; i < acc_cycle.size(); i++) begin
      checkOutput($sformatf("b2b_spacing%0d", i), acc_cycle[i] - acc_cycle[i-1], width + 2);
    end

    // Randomised operands and stalls against the arithmetic model
    for (int r = 0; r < 24; r++) begin
      ra = width'($urandom_range(0, 15));
      rb = width'($urandom_range(0, 15));
      applyStimulus(ra, rb, model_product(ra, rb), int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
